// File: rtl/db15_serial_joy_reader.sv
// Serial reader for two daisy-chained DB15 pads behind PISO shift registers.
// Emits one active-high 16-bit button word per player after a two-frame match.
module db15_serial_joy_reader #(
  parameter int CLK_DIV   = 24,
  parameter int GAP_TICKS = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  input  logic        JOY_DATA,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam logic [2:0] S_GAP    = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_M1 = 8'(GAP_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] prev_q, prev_d;
  logic [15:0] joy1_q, joy1_d;
  logic [15:0] joy2_q, joy2_d;
  logic        jclk_q, jclk_d;
  logic        jload_q, jload_d;
  logic        done_q, done_d;
  logic [1:0]  sync_q, sync_d;
  logic        tick;

  assign tick = (tick_cnt_q == DIV_M1);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
    gap_cnt_d  = gap_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    prev_d     = prev_q;
    joy1_d     = joy1_q;
    joy2_d     = joy2_q;
    jclk_d     = jclk_q;
    jload_d    = jload_q;
    done_d     = 1'b0;
    sync_d     = {sync_q[0], JOY_DATA};
    case (state_q)
      S_GAP: begin
        jclk_d  = 1'b1;
        jload_d = 1'b1;
        if (tick) begin
          if (gap_cnt_q == GAP_M1) begin
            gap_cnt_d = 8'd0;
            jload_d   = 1'b0;
            state_d   = S_LOAD;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
      end
      S_LOAD: begin
        if (tick) begin
          jload_d   = 1'b1;
          bit_cnt_d = 5'd0;
          state_d   = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        // LSB-first: after 32 shifts the first bit lands in shift[0]
        if (tick) begin
          shift_d = {sync_q[1], shift_q[31:1]};
          jclk_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          jclk_d = 1'b1;
          if (bit_cnt_q == 5'd31) begin
            state_d = S_UPDATE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = S_SAMPLE;
          end
        end
      end
      S_UPDATE: begin
        done_d    = 1'b1;
        gap_cnt_d = 8'd0;
        prev_d    = shift_q;
        state_d   = S_GAP;
        if (shift_q == prev_q) begin
          joy1_d = ~shift_q[15:0];
          joy2_d = ~shift_q[31:16];
        end
      end
      default: state_d = S_GAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_GAP;
      tick_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
      bit_cnt_q  <= 5'd0;
      shift_q    <= 32'hFFFF_FFFF;
      prev_q     <= 32'hFFFF_FFFF;
      joy1_q     <= 16'h0000;
      joy2_q     <= 16'h0000;
      jclk_q     <= 1'b1;
      jload_q    <= 1'b1;
      done_q     <= 1'b0;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      prev_q     <= prev_d;
      joy1_q     <= joy1_d;
      joy2_q     <= joy2_d;
      jclk_q     <= jclk_d;
      jload_q    <= jload_d;
      done_q     <= done_d;
      sync_q     <= sync_d;
    end
  end

  // frame_done is registered so the outputs already hold the new frame
  assign JOY_CLK    = jclk_q;
  assign JOY_LOAD   = jload_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_db15_serial_joy_reader.sv
// Bench for db15_serial_joy_reader: PISO pad model, frame scoreboard,
// handshake timing checks and mid-frame reset.
module tb_db15_serial_joy_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;

  db15_serial_joy_reader #(
    .CLK_DIV  (4),
    .GAP_TICKS(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .JOY_CLK   (JOY_CLK),
    .JOY_LOAD  (JOY_LOAD),
    .JOY_DATA  (JOY_DATA),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad chain: parallel load while JOY_LOAD low, advance on JOY_CLK rise
  logic [31:0] pad_word = 32'hFFFF_FFFF;
  logic [31:0] latched  = 32'hFFFF_FFFF;
  int          idx      = 32;

  always @(negedge JOY_LOAD) begin
    latched = pad_word;
    idx = 0;
  end

  always @(posedge JOY_CLK) if (JOY_LOAD && idx < 32) idx = idx + 1;

  assign JOY_DATA = (idx < 32) ? latched[idx] : 1'b1;

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && frame_done) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_frame: got frame_done expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("joystick1", {16'h0, joystick1}, {16'h0, e.j1});
        check("joystick2", {16'h0, joystick2}, {16'h0, e.j2});
      end
    end
  end

  task automatic push_exp(input logic [15:0] j1, input logic [15:0] j2);
    exp_t e;
    e.j1 = j1;
    e.j2 = j2;
    q.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 2000);
    if (!frame_done) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [31:0] w, input logic [15:0] j1,
                           input logic [15:0] j2);
    pad_word = w;
    push_exp(j1, j2);
    wait_done();
  endtask

  task automatic check_load_delay(input string name);
    int n;
    n = 0;
    while (JOY_LOAD && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, n, 8);
  endtask

  localparam logic [31:0] W1 = 32'hFFFE_FFDF;
  localparam logic [31:0] A  = 32'hF0F0_A55A;
  localparam logic [31:0] B  = 32'hF0F0_A552;

  initial begin
    int n;
    int pulses;
    int lowcyc;
    int t0;
    logic prev_clk;

    pad_word = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("rst_joy_clk", {31'h0, JOY_CLK}, 32'd1);
    check("rst_joy_load", {31'h0, JOY_LOAD}, 32'd1);
    check("rst_joystick1", {16'h0, joystick1}, 32'd0);
    check("rst_joystick2", {16'h0, joystick2}, 32'd0);
    check("rst_frame_done", {31'h0, frame_done}, 32'd0);

    reset = 1'b0;
    push_exp(16'h0000, 16'h0000);
    check_load_delay("load_delay");
    n = 0;
    while (!JOY_LOAD && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("load_width", n, 4);

    pulses = 0;
    lowcyc = 0;
    prev_clk = 1'b1;
    n = 0;
    while (!frame_done && n < 1000) begin
      @(negedge clk);
      n++;
      if (!JOY_CLK) lowcyc++;
      if (prev_clk && !JOY_CLK) pulses++;
      prev_clk = JOY_CLK;
    end
    check("clk_pulses", pulses, 32);
    check("clk_low_cycles", lowcyc, 128);

    t0 = cyc;
    run_frame(32'hFFFF_FFFF, 16'h0000, 16'h0000);
    check("frame_period", cyc - t0, 268);

    run_frame(W1, 16'h0000, 16'h0000);
    run_frame(W1, 16'h0020, 16'h0001);

    run_frame(A, 16'h0020, 16'h0001);
    run_frame(A, 16'h5AA5, 16'h0F0F);
    run_frame(B, 16'h5AA5, 16'h0F0F);
    run_frame(A, 16'h5AA5, 16'h0F0F);

    // Abort a frame right after bit 17 has been sampled
    pulses = 0;
    prev_clk = JOY_CLK;
    n = 0;
    while (pulses < 18 && n < 2000) begin
      @(negedge clk);
      n++;
      if (prev_clk && !JOY_CLK) pulses++;
      prev_clk = JOY_CLK;
    end
    check("mid_bit_count", pulses, 18);
    reset = 1'b1;
    #1;
    check("mid_rst_joy_clk", {31'h0, JOY_CLK}, 32'd1);
    check("mid_rst_joy_load", {31'h0, JOY_LOAD}, 32'd1);
    check("mid_rst_joystick1", {16'h0, joystick1}, 32'd0);
    check("mid_rst_joystick2", {16'h0, joystick2}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_exp(16'h0000, 16'h0000);
    check_load_delay("load_delay_after_rst");
    wait_done();
    run_frame(A, 16'h5AA5, 16'h0F0F);

    run_frame(32'hFFFF_FFFF, 16'h5AA5, 16'h0F0F);
    run_frame(32'hFFFF_FFFF, 16'h0000, 16'h0000);

    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
